// File: rtl/or_result_checker_if.sv
// Sample and result bundle between the OR-gate stimulus side and the hardware scoreboard.
`timescale 1ns/1ps
interface or_result_checker_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             err_flag;
    logic [CNT_W-1:0] first_err_idx;
    logic [WIDTH-1:0] first_err_a;
    logic [WIDTH-1:0] first_err_b;
    logic [WIDTH-1:0] first_err_y;

    modport master (
        output start, in_valid, a, b, y,
        input  busy, done, pass, match_cnt, mismatch_cnt, err_flag,
               first_err_idx, first_err_a, first_err_b, first_err_y
    );

    modport slave (
        input  start, in_valid, a, b, y,
        output busy, done, pass, match_cnt, mismatch_cnt, err_flag,
               first_err_idx, first_err_a, first_err_b, first_err_y
    );
endinterface

// File: rtl/or_result_checker.sv
// Hardware scoreboard for an OR gate: two-stage compare pipeline, saturating counters, first-error capture.
// Optional macro OR_CHECKER_STOP_ON_ERR_EN ends the run early on the first mismatch.
//
// state    | meaning
// ST_IDLE  | waiting for start after reset
// ST_RUN   | accepting samples until NUM_SAMPLES taken
// ST_DRAIN | no new samples, pipeline finishing compares
// ST_DONE  | results valid, waiting for next start
`timescale 1ns/1ps
module or_result_checker #(
    parameter int WIDTH       = 1,
    parameter int NUM_SAMPLES = 16,
    parameter int CNT_W       = 16
) (
    input logic              clk,
    input logic              rst_n,
    or_result_checker_if.slave chk_if
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sample_idx_q, sample_idx_d;

    logic             v1_q, v1_d;
    logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d, y1_q, y1_d;
    logic [CNT_W-1:0] idx1_q, idx1_d;

    logic             v2_q, v2_d;
    logic             mis2_q, mis2_d;
    logic [WIDTH-1:0] a2_q, a2_d, b2_q, b2_d, y2_q, y2_d;
    logic [CNT_W-1:0] idx2_q, idx2_d;

    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
    logic             err_flag_q, err_flag_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic [WIDTH-1:0] first_err_a_q, first_err_a_d;
    logic [WIDTH-1:0] first_err_b_q, first_err_b_d;
    logic [WIDTH-1:0] first_err_y_q, first_err_y_d;

    logic start_ok, accept, last_accept, mis1, stop_hit;
    logic busy_o, done_o;

    assign start_ok    = chk_if.start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign accept      = (state_q == ST_RUN) & chk_if.in_valid;
    assign last_accept = accept & (sample_idx_q == LAST_IDX);
    assign mis1        = v1_q & (y1_q != (a1_q | b1_q));

`ifdef OR_CHECKER_STOP_ON_ERR_EN
    // In RUN no earlier mismatch can exist, because the first one leaves RUN at once.
    assign stop_hit = (state_q == ST_RUN) & mis1;
`else
    assign stop_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (chk_if.start) state_d = ST_RUN;
            ST_RUN:   if (last_accept || stop_hit) state_d = ST_DRAIN;
            ST_DRAIN: if (!v1_q && !v2_q) state_d = ST_DONE;
            ST_DONE:  if (chk_if.start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == ST_RUN) | (state_q == ST_DRAIN);
        done_o = (state_q == ST_DONE);
    end

    always_comb begin
        sample_idx_d    = sample_idx_q;
        v1_d            = accept;
        a1_d            = a1_q;
        b1_d            = b1_q;
        y1_d            = y1_q;
        idx1_d          = idx1_q;
        v2_d            = v1_q;
        mis2_d          = mis1;
        a2_d            = a2_q;
        b2_d            = b2_q;
        y2_d            = y2_q;
        idx2_d          = idx2_q;
        match_cnt_d     = match_cnt_q;
        mismatch_cnt_d  = mismatch_cnt_q;
        err_flag_d      = err_flag_q;
        first_err_idx_d = first_err_idx_q;
        first_err_a_d   = first_err_a_q;
        first_err_b_d   = first_err_b_q;
        first_err_y_d   = first_err_y_q;

        if (accept) begin
            a1_d         = chk_if.a;
            b1_d         = chk_if.b;
            y1_d         = chk_if.y;
            idx1_d       = sample_idx_q;
            sample_idx_d = sample_idx_q + 1'b1;
        end

        if (v1_q) begin
            a2_d   = a1_q;
            b2_d   = b1_q;
            y2_d   = y1_q;
            idx2_d = idx1_q;
        end

        // The pipeline is always empty in IDLE/DONE, so a start never collides with a counter update.
        if (start_ok) begin
            sample_idx_d    = '0;
            match_cnt_d     = '0;
            mismatch_cnt_d  = '0;
            err_flag_d      = 1'b0;
            first_err_idx_d = '0;
            first_err_a_d   = '0;
            first_err_b_d   = '0;
            first_err_y_d   = '0;
        end else if (v2_q) begin
            if (mis2_q) begin
                if (mismatch_cnt_q != CNT_MAX) mismatch_cnt_d = mismatch_cnt_q + 1'b1;
                if (!err_flag_q) begin
                    err_flag_d      = 1'b1;
                    first_err_idx_d = idx2_q;
                    first_err_a_d   = a2_q;
                    first_err_b_d   = b2_q;
                    first_err_y_d   = y2_q;
                end
            end else if (match_cnt_q != CNT_MAX) begin
                match_cnt_d = match_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_idx_q    <= '0;
            v1_q            <= 1'b0;
            a1_q            <= '0;
            b1_q            <= '0;
            y1_q            <= '0;
            idx1_q          <= '0;
            v2_q            <= 1'b0;
            mis2_q          <= 1'b0;
            a2_q            <= '0;
            b2_q            <= '0;
            y2_q            <= '0;
            idx2_q          <= '0;
            match_cnt_q     <= '0;
            mismatch_cnt_q  <= '0;
            err_flag_q      <= 1'b0;
            first_err_idx_q <= '0;
            first_err_a_q   <= '0;
            first_err_b_q   <= '0;
            first_err_y_q   <= '0;
        end else begin
            sample_idx_q    <= sample_idx_d;
            v1_q            <= v1_d;
            a1_q            <= a1_d;
            b1_q            <= b1_d;
            y1_q            <= y1_d;
            idx1_q          <= idx1_d;
            v2_q            <= v2_d;
            mis2_q          <= mis2_d;
            a2_q            <= a2_d;
            b2_q            <= b2_d;
            y2_q            <= y2_d;
            idx2_q          <= idx2_d;
            match_cnt_q     <= match_cnt_d;
            mismatch_cnt_q  <= mismatch_cnt_d;
            err_flag_q      <= err_flag_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_a_q   <= first_err_a_d;
            first_err_b_q   <= first_err_b_d;
            first_err_y_q   <= first_err_y_d;
        end
    end

    assign chk_if.busy          = busy_o;
    assign chk_if.done          = done_o;
    assign chk_if.pass          = done_o & (mismatch_cnt_q == '0);
    assign chk_if.match_cnt     = match_cnt_q;
    assign chk_if.mismatch_cnt  = mismatch_cnt_q;
    assign chk_if.err_flag      = err_flag_q;
    assign chk_if.first_err_idx = first_err_idx_q;
    assign chk_if.first_err_a   = first_err_a_q;
    assign chk_if.first_err_b   = first_err_b_q;
    assign chk_if.first_err_y   = first_err_y_q;

endmodule

// File: tb/tb_or_result_checker.sv
// Self-checking bench for or_result_checker: directed scenarios plus randomized runs against a list-based model.
`timescale 1ns/1ps
module tb_or_result_checker;
    localparam int W  = 1;
    localparam int N  = 16;
    localparam int CW = 16;
`ifdef OR_CHECKER_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    or_result_checker_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    or_result_checker #(.WIDTH(W), .NUM_SAMPLES(N), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .chk_if (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] sa [N];
    logic [W-1:0] sb [N];
    logic [W-1:0] sy [N];

    int           exp_first, exp_acc, exp_match, exp_mis;
    logic [W-1:0] exp_fa, exp_fb, exp_fy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < N; i++) begin
            int k;
            k = i % 4;
            sa[i] = W'(k >> 1);
            sb[i] = W'(k & 1);
            sy[i] = sa[i] | sb[i];
        end
    endtask

    task automatic fill_random(input int fault_pct);
        for (int i = 0; i < N; i++) begin
            sa[i] = W'($urandom);
            sb[i] = W'($urandom);
            sy[i] = sa[i] | sb[i];
            if ($urandom_range(99, 0) < fault_pct) sy[i] = ~sy[i];
        end
    endtask

    task automatic plant_fault(input int i);
        sy[i] = ~(sa[i] | sb[i]);
    endtask

    // Reference: scan the sample list for the run outcome; stop-on-error keeps the faulty
    // sample plus the one accepted alongside its detection (valid every cycle).
    task automatic predict();
        exp_first = -1;
        for (int i = 0; i < N; i++)
            if (exp_first < 0 && sy[i] != (sa[i] | sb[i])) exp_first = i;
        exp_acc = N;
        if (STOP && exp_first >= 0 && exp_first + 2 < N) exp_acc = exp_first + 2;
        exp_match = 0;
        exp_mis   = 0;
        for (int i = 0; i < exp_acc; i++)
            if (sy[i] == (sa[i] | sb[i])) exp_match++;
            else exp_mis++;
        exp_fa = '0; exp_fb = '0; exp_fy = '0;
        if (exp_first >= 0) begin
            exp_fa = sa[exp_first];
            exp_fb = sb[exp_first];
            exp_fy = sy[exp_first];
        end
    endtask

    task automatic do_run(input string name, input int gap_max, input bit start_mid, input int pre_noise);
        int  lat, gmax;
        bit  early;
        predict();
        early = (exp_acc < N);
        gmax  = (STOP && exp_first >= 0) ? 0 : gap_max;
        for (int k = 0; k < pre_noise; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a = W'($urandom); bus.b = W'($urandom); bus.y = W'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({name, "_busy_at_start"}, bus.busy, 1);
        for (int i = 0; i < N; i++) begin
            int g;
            g = $urandom_range(gmax, 0);
            repeat (g) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.start    = 1'b0;
                if (!early) check_eq({name, "_busy_gap"}, bus.busy, 1);
            end
            @(negedge clk);
            if (!early) check_eq({name, "_busy"}, bus.busy, 1);
            if (early && i == N - 1 && exp_acc <= N - 4)
                check_eq({name, "_done_early"}, bus.done, 1);
            bus.in_valid = 1'b1;
            bus.a = sa[i]; bus.b = sb[i]; bus.y = sy[i];
            bus.start = start_mid && (i == 6);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        lat = 1;
        while (!bus.done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq({name, "_done"}, bus.done, 1);
        if (!early) check_eq({name, "_done_within_3clk"}, 32'(lat <= 4), 1);
        check_eq({name, "_busy_end"}, bus.busy, 0);
        check_eq({name, "_match_cnt"}, bus.match_cnt, exp_match);
        check_eq({name, "_mismatch_cnt"}, bus.mismatch_cnt, exp_mis);
        check_eq({name, "_pass"}, bus.pass, 32'(exp_mis == 0));
        check_eq({name, "_err_flag"}, bus.err_flag, 32'(exp_first >= 0));
        check_eq({name, "_first_err_idx"}, bus.first_err_idx, (exp_first >= 0) ? exp_first : 0);
        check_eq({name, "_first_err_a"}, bus.first_err_a, exp_fa);
        check_eq({name, "_first_err_b"}, bus.first_err_b, exp_fb);
        check_eq({name, "_first_err_y"}, bus.first_err_y, exp_fy);
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, "_busy"}, bus.busy, 0);
        check_eq({name, "_done"}, bus.done, 0);
        check_eq({name, "_pass"}, bus.pass, 0);
        check_eq({name, "_match_cnt"}, bus.match_cnt, 0);
        check_eq({name, "_mismatch_cnt"}, bus.mismatch_cnt, 0);
        check_eq({name, "_err_flag"}, bus.err_flag, 0);
        check_eq({name, "_first_err_idx"}, bus.first_err_idx, 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0;
        bus.a = '0; bus.b = '0; bus.y = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        fill_pattern();
        do_run("all_ok", 0, 1'b0, 0);

        fill_pattern();
        plant_fault(5);
        do_run("single_fault", 0, 1'b0, 0);

        fill_pattern();
        do_run("gaps", 3, 1'b0, 3);

        fill_pattern();
        plant_fault(2); plant_fault(7); plant_fault(15);
        do_run("multi_fault", 0, 1'b0, 0);

        // Abort a run with a fault already counted, then verify a clean rerun.
        fill_pattern();
        plant_fault(2);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.a = sa[i]; bus.b = sb[i]; bus.y = sy[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check_eq("pre_reset_err_flag", bus.err_flag, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_run_reset");
        @(negedge clk);
        rst_n = 1'b1;
        fill_pattern();
        do_run("after_reset", 0, 1'b1, 0);

        fill_pattern();
        plant_fault(3);
        do_run("fault_at_3", 0, 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            fill_random(12);
            do_run($sformatf("rand%0d", r), 3, 1'(r % 2), $urandom_range(2, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/or_result_checker.md
Name: or_result_checker

Overview:
- Hardware scoreboard directly downstream of the OR-gate DUT.
- Consumes the same A/B/Y signals the bench monitor watches.
- Registers each valid sample, computes expected = A | B and compares it against Y.
- Keeps match and mismatch counts, captures the first failing transaction, and reports pass/fail after a programmed number of samples.

Parameters:
- WIDTH, 1: bit width of a, b, y.
- NUM_SAMPLES, 16: samples accepted per run (must be at least 1).
- CNT_W, 16: width of counters and sample index.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  one-cycle pulse that begins a run.
- in_valid  input  1  a/b/y carry a sample this cycle.
- a  input  WIDTH  DUT operand A.
- b  input  WIDTH  DUT operand B.
- y  input  WIDTH  DUT result Y.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE; held until next start.
- pass  output  1  valid while done: 1 if mismatch_cnt == 0.
- match_cnt  output  CNT_W  compared samples with y == a|b.
- mismatch_cnt  output  CNT_W  compared samples with y != a|b.
- err_flag  output  1  sticky; set on the first mismatch of a run.
- first_err_idx  output  CNT_W  sample index (0-based) of the first mismatch.
- first_err_a  output  WIDTH  a of the first mismatch.
- first_err_b  output  WIDTH  b of the first mismatch.
- first_err_y  output  WIDTH  y of the first mismatch.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE and all outputs 0, including counters, err_flag and first_err_*. The pipeline valid bits also clear.
- Reset mid-run aborts immediately; no partial results are retained.
- FSM IDLE -> RUN: start = 1. On that edge match_cnt, mismatch_cnt, err_flag, first_err_* and sample_idx clear to 0.
- FSM DONE -> RUN: start = 1, with the same clears. done drops on the same edge.
- FSM RUN -> DRAIN: on the edge that accepts sample NUM_SAMPLES-1. No further samples are accepted.
- FSM DRAIN -> DONE: once the pipeline is empty (both stage-valid bits 0).
- start in RUN or DRAIN is ignored.
- in_valid outside RUN is ignored; it does not advance the index or the counters.
- Pipeline stage 1: in RUN, in_valid = 1 captures a, b, y, the current sample_idx and v1 = 1; sample_idx then increments.
- Pipeline stage 2: computes exp = a_r | b_r bitwise over WIDTH and compares it with y_r. Counters update on the following edge, so latency from accepted sample to counter update is 2 clocks.
- First mismatch: when err_flag = 0, load first_err_* and set err_flag. Later mismatches update only mismatch_cnt.
- Counters saturate at 2^CNT_W - 1 and do not wrap.
- sample_idx is CNT_W bits. NUM_SAMPLES must be at most 2^CNT_W; larger values are illegal.
- Back-to-back in_valid every cycle is supported; there is no stall or ready signal.
- pass is combinational: done & (mismatch_cnt == 0). It is 0 outside DONE.
- busy = (state == RUN) | (state == DRAIN).

Optional Feature:
- Macro: OR_CHECKER_STOP_ON_ERR_EN.
- Defined: the first mismatch detected in stage 2 forces the FSM straight to DRAIN and stage 1 stops accepting input from that edge. The remaining pipeline contents are still compared and counted, then the FSM reaches DONE early with pass = 0.
- Not defined: the run always accepts exactly NUM_SAMPLES samples regardless of errors.

Test Plan:
- All correct: reset, start, then 16 valid samples cycling through (a,b) = 00, 01, 10, 11 with correct y. Required: done asserts at most 3 clocks after the last sample; match_cnt = 16, mismatch_cnt = 0, pass = 1, err_flag = 0.
- Single fault: sample 5 is a = 0, b = 1, y = 0, all others correct. Required: mismatch_cnt = 1, match_cnt = 15, pass = 0, first_err_idx = 5, first_err_a/b/y = 0/1/0.
- Gaps in valid: 16 samples interleaved with in_valid = 0 gaps of 0–3 cycles, plus in_valid = 1 pulses before start. Required: only the 16 in-run samples are counted (match_cnt = 16), and busy stays high throughout the run.
- Multiple faults: mismatches at samples 2, 7 and 15. Required: first_err_idx = 2 with the captures from sample 2; mismatch_cnt = 3.
- Reset during run: assert rst_n = 0 after 8 samples, release, start, then run 16 clean samples. Required: outputs are 0 immediately on reset; the new run ends with match_cnt = 16 and pass = 1. Also: start pulsed during RUN has no effect.
- OR_CHECKER_STOP_ON_ERR_EN defined, fault at sample 3, valid every cycle: samples 0..4 are accepted, and done asserts well before 16 samples. Required: mismatch_cnt = 1, pass = 0, match_cnt = 4, first_err_idx = 3.
